soc_pio_irq_in: RTL and testbench

//  Parametrised Avalon-MM slave input port with edge capture and interrupt generation. Successor to the

---
 rtl/soc_pio_pkg.sv | 8 +
 rtl/soc_pio_debounce.sv | 27 ++
 rtl/soc_pio_irq_in.sv | 78 +++++++
 tb/tb_soc_pio_irq_in.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/soc_pio_pkg.sv
// soc_pio_pkg: register map addresses and edge-mode encoding for the PIO input port
package soc_pio_pkg;
    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_MASK = 2'd1;
    localparam logic [1:0] ADDR_RSVD = 2'd2;
    localparam logic [1:0] ADDR_EDGE = 2'd3;
    typedef enum logic [1:0] {EDGE_RISE, EDGE_FALL, EDGE_ANY} edge_mode_e;
endpackage

// File: rtl/soc_pio_debounce.sv
// soc_pio_debounce: single-bit filter, output follows input after DEB_CYCLES consecutive differing clocks
module soc_pio_debounce #(
    parameter int DEB_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);
    localparam int CW = $clog2(DEB_CYCLES);
    logic [CW-1:0] cnt_q, cnt_d;
    logic out_q, out_d;
    always_comb begin
        out_d = (d != out_q && cnt_q == CW'(DEB_CYCLES - 1)) ? d : out_q;
        cnt_d = (d == out_q || cnt_q == CW'(DEB_CYCLES - 1)) ? '0 : cnt_q + CW'(1);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            out_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            out_q <= out_d;
        end
    end
    assign q = out_q;
endmodule

// File: rtl/soc_pio_irq_in.sv
// soc_pio_irq_in: Avalon-MM PIO input with edge capture and irq; PIO_IRQ_IN_DEBOUNCE_EN adds a per-bit debounce filter
module soc_pio_irq_in #(
    parameter int WIDTH       = 8,
    parameter int EDGE_MODE   = 0,
    parameter int SYNC_STAGES = 2,
    parameter int DEB_CYCLES  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);
    import soc_pio_pkg::*;
    localparam edge_mode_e MODE = edge_mode_e'(EDGE_MODE);
    localparam int AW = $clog2(SYNC_STAGES + 2);
    localparam logic [AW-1:0] ARM_MAX = AW'(SYNC_STAGES + 1);
    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
    logic [WIDTH-1:0] data_s, data_f, prev_q, prev_d, mask_q, mask_d, edge_q, edge_d, clr, hit;
    logic [AW-1:0] arm_q, arm_d;
    logic [31:0] rd_q, rd_d;
    logic irq_q, irq_d, wr, armed, unused_ok;
    assign data_s = sync_q[SYNC_STAGES-1];
`ifdef PIO_IRQ_IN_DEBOUNCE_EN
    for (genvar i = 0; i < WIDTH; i++) begin : g_deb
        soc_pio_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
            .clk  (clk),
            .reset(reset),
            .d    (data_s[i]),
            .q    (data_f[i])
        );
    end
`else
    assign data_f = data_s;
`endif
    always_comb begin
        wr     = chipselect && !write_n;
        armed  = arm_q == ARM_MAX;
        sync_d = {sync_q[SYNC_STAGES-2:0], in_port};
        prev_d = data_f;
        arm_d  = armed ? arm_q : arm_q + AW'(1);
        hit    = MODE == EDGE_RISE ? data_f & ~prev_q :
                 MODE == EDGE_FALL ? ~data_f & prev_q : data_f ^ prev_q;
        clr    = (wr && address == ADDR_EDGE) ? writedata[WIDTH-1:0] : '0;
        edge_d = (edge_q & ~clr) | (armed ? hit : '0);
        mask_d = (wr && address == ADDR_MASK) ? writedata[WIDTH-1:0] : mask_q;
        irq_d  = |(edge_q & mask_q);
        rd_d   = address == ADDR_DATA ? 32'(data_f) :
                 address == ADDR_MASK ? 32'(mask_q) :
                 address == ADDR_RSVD ? 32'd0 : 32'(edge_q);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
            prev_q <= '0;
            mask_q <= '0;
            edge_q <= '0;
            arm_q  <= '0;
            rd_q   <= '0;
            irq_q  <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
            mask_q <= mask_d;
            edge_q <= edge_d;
            arm_q  <= arm_d;
            rd_q   <= rd_d;
            irq_q  <= irq_d;
        end
    end
    assign readdata  = rd_q;
    assign irq       = irq_q;
    assign unused_ok = ^{writedata, DEB_CYCLES};
endmodule

// File: tb/tb_soc_pio_irq_in.sv
// tb_soc_pio_irq_in: directed scoreboard bench for soc_pio_irq_in (8-bit and 4-bit instances)
module tb_soc_pio_irq_in;
    localparam int S = 2;
    localparam int DEB = 16;
`ifdef PIO_IRQ_IN_DEBOUNCE_EN
    localparam int LAT = S + DEB + 1;
`else
    localparam int LAT = S + 1;
`endif
    logic clk = 1'b0;
    logic reset, chipselect, write_n, irq, irq4;
    logic [1:0] address;
    logic [31:0] writedata, readdata, readdata4;
    logic [7:0] in_port;
    logic [3:0] in_port4;
    int n_tests = 0;
    int n_fail = 0;
    string tag_q[$];
    logic [31:0] exp_q[$];
    always #5 clk = ~clk;
    soc_pio_irq_in #(.WIDTH(8), .EDGE_MODE(0), .SYNC_STAGES(S), .DEB_CYCLES(DEB)) dut (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write_n(write_n),
        .writedata(writedata), .readdata(readdata), .in_port(in_port), .irq(irq)
    );
    soc_pio_irq_in #(.WIDTH(4), .EDGE_MODE(0), .SYNC_STAGES(S), .DEB_CYCLES(DEB)) dut4 (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write_n(write_n),
        .writedata(writedata), .readdata(readdata4), .in_port(in_port4), .irq(irq4)
    );
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    task automatic rd(input logic [1:0] a, input string tag, input logic [31:0] exp);
        string t;
        logic [31:0] e;
        address = a;
        tag_q.push_back(tag);
        exp_q.push_back(exp);
        @(negedge clk);
        t = tag_q.pop_front();
        e = exp_q.pop_front();
        chk(t, readdata, e);
    endtask
    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        chipselect = 1'b1;
        write_n = 1'b0;
        address = a;
        writedata = d;
        @(negedge clk);
        chipselect = 1'b0;
        write_n = 1'b1;
        writedata = '0;
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end
    initial begin
        reset = 1'b1; chipselect = 1'b0; write_n = 1'b1; address = 2'd0; writedata = '0;
        in_port = 8'hFF; in_port4 = 4'h0;
        repeat (3) @(negedge clk);
        chk("rst_readdata", readdata, 32'h0);
        chk("rst_irq", {31'b0, irq}, 32'h0);
        reset = 1'b0;
        repeat (S + 3) rd(2'd3, "arm_edgecap", 32'h0);
        repeat (LAT + 2) @(negedge clk);
        rd(2'd0, "arm_data", 32'hFF);
        in_port = 8'h00;
        repeat (LAT + 3) @(negedge clk);
        wr(2'd3, 32'hFF);
        rd(2'd3, "clean_edgecap", 32'h0);
        wr(2'd1, 32'h05);
        in_port = 8'h01;
        repeat (LAT) begin
            rd(2'd3, "rise_pre", 32'h0);
            chk("rise_irq_pre", {31'b0, irq}, 32'h0);
        end
        rd(2'd3, "rise_cap", 32'h01);
        chk("rise_irq", {31'b0, irq}, 32'h1);
        wr(2'd3, 32'h01);
        chk("clr_irq_hold", {31'b0, irq}, 32'h1);
        rd(2'd3, "clr_edgecap", 32'h0);
        chk("clr_irq", {31'b0, irq}, 32'h0);
        wr(2'd1, 32'h00);
        in_port = 8'h81;
        repeat (LAT + 1) @(negedge clk);
        rd(2'd3, "mask_edgecap", 32'h80);
        chk("mask_irq_off", {31'b0, irq}, 32'h0);
        wr(2'd1, 32'h80);
        chk("mask_irq_hold", {31'b0, irq}, 32'h0);
        @(negedge clk);
        chk("mask_irq_on", {31'b0, irq}, 32'h1);
        wr(2'd3, 32'hFF);
        wr(2'd1, 32'h00);
        in_port = 8'h85;
        repeat (LAT - 1) @(negedge clk);
        wr(2'd3, 32'h04);
        rd(2'd3, "collide_set_wins", 32'h04);
        in_port = 8'h00;
        repeat (LAT + 2) @(negedge clk);
        rd(2'd3, "fall_ignored", 32'h04);
        wr(2'd3, 32'hFF);
        wr(2'd1, 32'h05);
        wr(2'd0, 32'hFFFF_FFFF);
        rd(2'd0, "map_data", 32'h0);
        rd(2'd1, "map_mask_keep", 32'h05);
        rd(2'd3, "map_edge_keep", 32'h0);
        wr(2'd2, 32'hFFFF_FFFF);
        rd(2'd2, "map_rsvd", 32'h0);
        rd(2'd1, "map_mask_keep2", 32'h05);
        wr(2'd1, 32'hFFFF_FFFF);
        rd(2'd1, "map_mask_w8", 32'h0000_00FF);
        chk("map_mask_w4", readdata4, 32'h0000_000F);
        in_port = 8'h01;
        repeat (LAT + 2) @(negedge clk);
        chk("midrst_irq_pre", {31'b0, irq}, 32'h1);
        reset = 1'b1;
        in_port = 8'h00;
        @(negedge clk);
        reset = 1'b0;
        chk("midrst_irq", {31'b0, irq}, 32'h0);
        chk("midrst_readdata", readdata, 32'h0);
        rd(2'd3, "midrst_edgecap", 32'h0);
        rd(2'd1, "midrst_mask", 32'h0);
`ifdef PIO_IRQ_IN_DEBOUNCE_EN
        repeat (S + 3) @(negedge clk);
        in_port = 8'h01;
        repeat (10) @(negedge clk);
        in_port = 8'h00;
        repeat (LAT + 4) @(negedge clk);
        rd(2'd3, "deb_glitch", 32'h0);
        in_port = 8'h01;
        repeat (LAT) rd(2'd3, "deb_pre", 32'h0);
        rd(2'd3, "deb_cap", 32'h01);
        in_port = 8'h00;
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
